// File: rtl/uart_pkg.sv
// Shared constants and types for the configurable UART transmitter.
// Holds the parity-mode codes, the FSM state encoding and the legal DATA_W range.
package uart_pkg;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Narrower words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [1:0] mode, input logic [DATA_W_MAX-1:0] data);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO for the UART transmitter: power-of-two depth, wrapping pointers,
// occupancy counter; push is ignored when full and pop is ignored when empty.
module tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 pop_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a transmit FIFO, run-time parity mode and 1/2 stop bits.
// Frame configuration is captured when a word is popped, so it holds for the whole frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              tx_valid,
    input  logic [DATA_W-1:0]                 tx_data_in,
    output logic                              tx_ready,
    input  logic [1:0]                        parity_mode,
    input  logic                              two_stop,
    output logic                              tx_data_out,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam int unsigned   IW       = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || CLKS_PER_BIT < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_cfg: illegal parameter set");
    end

    tx_state_t         state;
    tx_state_t         state_next;
    logic              load;
    logic              line_next;
    logic [CW-1:0]     baud_cnt;
    logic              bit_end;
    logic [IW-1:0]     bit_idx;
    logic              stop_idx;
    logic [DATA_W-1:0] shift_q;
    logic              par_bit_q;
    logic              par_en_q;
    logic              two_stop_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;

    tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data_in),
        .pop       (load),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state != ST_IDLE) || !fifo_empty;
    assign bit_end  = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // load marks every entry into START; it is also the FIFO pop.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            ST_IDLE: if (!fifo_empty) begin
                state_next = ST_START;
                load       = 1'b1;
            end
            ST_START:  if (bit_end) state_next = ST_DATA;
            ST_DATA:   if (bit_end && bit_idx == IDX_LAST) state_next = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_next = ST_STOP;
            ST_STOP: if (bit_end && stop_idx == two_stop_q) begin
                if (!fifo_empty) begin
                    state_next = ST_START;
                    load       = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Line value for the current state; registered below, so the line lags the state by one cycle.
    always_comb begin
        line_next = 1'b1;
        case (state)
            ST_START:  line_next = 1'b0;
            ST_DATA:   line_next = shift_q[0];
            ST_PARITY: line_next = par_bit_q;
            default:   line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data_out <= 1'b1;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            two_stop_q  <= 1'b0;
        end else begin
            tx_data_out <= line_next;
            if (state == ST_IDLE || bit_end) baud_cnt <= '0;
            else                             baud_cnt <= baud_cnt + CW'(1);
            if (load) begin
                shift_q    <= fifo_data;
                par_bit_q  <= parity_bit(parity_mode, DATA_W_MAX'(fifo_data));
                par_en_q   <= (parity_mode != PAR_NONE);
                two_stop_q <= two_stop;
                bit_idx    <= '0;
                stop_idx   <= 1'b0;
            end else if (bit_end) begin
                if (state == ST_DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_idx <= bit_idx + IW'(1);
                end
                if (state == ST_STOP) stop_idx <= ~stop_idx;
            end
        end
    end

endmodule
